mmio_id_bridge: RTL and testbench
=================================

MMIO_ID_BRIDGE -- requirements
Module: mmio_id_bridge

Interface
REQ-001 Parameter ID_WIDTH, default 9: width of the host MMIO AXI-lite ID tags.
REQ-002 Parameter ADDR_IN_WIDTH, default 18: host MMIO address width.
REQ-003 Parameter ADDR_OUT_WIDTH, default 32: kernel-side slave address width.
REQ-004 Parameter DATA_WIDTH, default 64: MMIO data width. Strobe width is DATA_WIDTH/8.
REQ-005 Parameter DEPTH, default 4: maximum outstanding transactions per direction. Power of two, >=2.
REQ-006 Port clk, in, 1: single clock for all logic.
REQ-007 Port reset, in, 1: asynchronous, active-high reset.
REQ-008 Port group s_ar{valid,ready,addr,id}, in/out/in/in, 1/1/ADDR_IN_WIDTH/ID_WIDTH: host read address.
REQ-009 Port group s_r{valid,ready,data,resp,id}, out/in/out/out/out, 1/1/DATA_WIDTH/2/ID_WIDTH: host read response.
REQ-010 Port group s_aw{valid,ready,addr,id}: host write address; directions and widths as s_ar.
REQ-011 Port group s_w{valid,ready,data,strb}, in/out/in/in: host write data.
REQ-012 Port group s_b{valid,ready,resp,id}, out/in/out/out, 1/1/2/ID_WIDTH: host write response.
REQ-013 Port groups m_ar, m_r, m_aw, m_w, m_b: the same channels without IDs toward the kernel slave. Addresses are ADDR_OUT_WIDTH wide. Directions are mirrored.
REQ-014 Ports rd_outstanding and wr_outstanding, out, $clog2(DEPTH+1) each: live in-flight counts.
REQ-015 Port err_orphan, out, 1: sticky flag; a response arrived with no pending ID.

Function
REQ-016 ID tracking: each direction SHALL have one in-order ID FIFO of DEPTH entries.
- Push s_arid on each AR handshake; push s_awid on each AW handshake.
REQ-017 m_arvalid SHALL equal s_arvalid AND NOT rd_full.
REQ-018 s_arready SHALL equal m_arready AND NOT rd_full. AW behaves identically against wr_full.
REQ-019 Address mapping SHALL be combinational.
- Zero-extend when ADDR_OUT_WIDTH > ADDR_IN_WIDTH.
- Otherwise truncate to the low ADDR_OUT_WIDTH bits.
REQ-020 The W channel SHALL pass straight through (valid, ready, data, strb), independent of wr_full.
REQ-021 s_rvalid SHALL equal m_rvalid AND NOT rd_empty, and m_rready SHALL equal s_rready AND NOT rd_empty.
- s_rid SHALL be the FIFO head.
- s_rdata and s_rresp pass through.
- Pop on R handshake. B behaves identically against the write FIFO.
REQ-022 Latency: zero cycles combinational on all pass-through paths. A pushed ID is visible at the FIFO head on the next cycle.
REQ-023 Simultaneous push and pop in one cycle SHALL keep the count unchanged and preserve order.
- A push when full is impossible, because AR/AW are gated.
- A pop when empty is impossible, because R/B are gated.
REQ-024 Counters SHALL increment on push and decrement on pop, be unchanged on simultaneous push and pop, and saturate at DEPTH.
REQ-025 FIFO pointers SHALL wrap modulo DEPTH with no lost or duplicated entries.
REQ-026 err_orphan SHALL set when m_rvalid or m_bvalid is high while the matching FIFO is empty. It stays set until reset. The orphan response is held, not forwarded.

Reset
REQ-027 While reset is high:
- FIFOs empty and counters 0.
- err_orphan 0.
- All s_*valid and m_*valid outputs 0.
- All ready outputs 0.
REQ-028 Reset mid-transaction SHALL discard all pending IDs. The first response after release with no pending ID sets err_orphan.

Structure
REQ-029 Package mmio_id_pkg SHALL hold the default parameter constants and the AXI resp encodings (OKAY=2'b00, SLVERR=2'b10).
REQ-030 One sub-module, mmio_id_fifo, SHALL be instantiated twice (read, write). Parameters: WIDTH, DEPTH. Outputs: full, empty, count.

Verification
REQ-031 Read order: issue AR ids 0x11, 0x22, 0x33, with the slave answering in order -> s_rid sequence 0x11, 0x22, 0x33; rd_outstanding peaks at 3, then returns to 0.
REQ-032 Full back-pressure with DEPTH=4: issue 5 ARs with no R -> the 5th AR has s_arready=0 and m_arvalid=0; after one R handshake it proceeds next cycle.
REQ-033 Wrap-around: 10 back-to-back write transactions with ids 0..9 and a 1-cycle B delay -> s_bid equals 0..9 in order; wr_outstanding never exceeds 2.
REQ-034 Simultaneous events: AR push and R pop in the same cycle at count 2 -> count stays 2 and the next s_rid is the older ID.
REQ-035 Orphan: assert m_rvalid with an empty FIFO -> err_orphan=1 next cycle and s_rvalid=0; err_orphan is cleared only by reset.
REQ-036 Address mapping: s_araddr=18'h3FFFF with ADDR_OUT_WIDTH=32 -> m_araddr=32'h0003FFFF; async reset mid-burst -> all valid/ready outputs 0 immediately.

Source files
------------

// File: rtl/mmio_id_pkg.sv
// Shared constants for the MMIO ID bridge: default parameter values and AXI
// response encodings.
package mmio_id_pkg;
  localparam int ID_WIDTH_DEF       = 9;
  localparam int ADDR_IN_WIDTH_DEF  = 18;
  localparam int ADDR_OUT_WIDTH_DEF = 32;
  localparam int DATA_WIDTH_DEF     = 64;
  localparam int DEPTH_DEF          = 4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
endpackage

// File: rtl/mmio_id_fifo.sv
// In-order ID FIFO: remembers host IDs of outstanding requests so responses
// from the ID-less kernel slave can be tagged in issue order.
module mmio_id_fifo #(
  parameter int  WIDTH = 9,
  parameter int  DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push_ok && !pop_ok)      count_d = count_q + CNT_W'(1);
    else if (pop_ok && !push_ok) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
endmodule

// File: rtl/mmio_id_bridge.sv
// Bridges an ID-tagged host AXI-lite MMIO port to an ID-less kernel slave,
// restoring IDs on responses from per-direction in-order FIFOs.
module mmio_id_bridge
  import mmio_id_pkg::*;
#(
  parameter int  ID_WIDTH       = ID_WIDTH_DEF,
  parameter int  ADDR_IN_WIDTH  = ADDR_IN_WIDTH_DEF,
  parameter int  ADDR_OUT_WIDTH = ADDR_OUT_WIDTH_DEF,
  parameter int  DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int  DEPTH          = DEPTH_DEF,
  localparam int CNT_W          = $clog2(DEPTH + 1),
  localparam int STRB_W         = DATA_WIDTH / 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      s_arvalid,
  output logic                      s_arready,
  input  logic [ADDR_IN_WIDTH-1:0]  s_araddr,
  input  logic [ID_WIDTH-1:0]       s_arid,
  output logic                      s_rvalid,
  input  logic                      s_rready,
  output logic [DATA_WIDTH-1:0]     s_rdata,
  output logic [1:0]                s_rresp,
  output logic [ID_WIDTH-1:0]       s_rid,
  input  logic                      s_awvalid,
  output logic                      s_awready,
  input  logic [ADDR_IN_WIDTH-1:0]  s_awaddr,
  input  logic [ID_WIDTH-1:0]       s_awid,
  input  logic                      s_wvalid,
  output logic                      s_wready,
  input  logic [DATA_WIDTH-1:0]     s_wdata,
  input  logic [STRB_W-1:0]         s_wstrb,
  output logic                      s_bvalid,
  input  logic                      s_bready,
  output logic [1:0]                s_bresp,
  output logic [ID_WIDTH-1:0]       s_bid,
  output logic                      m_arvalid,
  input  logic                      m_arready,
  output logic [ADDR_OUT_WIDTH-1:0] m_araddr,
  input  logic                      m_rvalid,
  output logic                      m_rready,
  input  logic [DATA_WIDTH-1:0]     m_rdata,
  input  logic [1:0]                m_rresp,
  output logic                      m_awvalid,
  input  logic                      m_awready,
  output logic [ADDR_OUT_WIDTH-1:0] m_awaddr,
  output logic                      m_wvalid,
  input  logic                      m_wready,
  output logic [DATA_WIDTH-1:0]     m_wdata,
  output logic [STRB_W-1:0]         m_wstrb,
  input  logic                      m_bvalid,
  output logic                      m_bready,
  input  logic [1:0]                m_bresp,
  output logic [CNT_W-1:0]          rd_outstanding,
  output logic [CNT_W-1:0]          wr_outstanding,
  output logic                      err_orphan
);
  // Handshake rule on every channel: a transfer happens on a rising clk edge
  // where valid and ready are both high; the bridge only gates, never stores.
  logic rd_full, rd_empty, wr_full, wr_empty;
  logic ar_hs, r_hs, aw_hs, b_hs, run;
  logic err_orphan_q, err_orphan_d;

  // Request channels are forced idle while reset is held, even with room.
  assign run       = ~reset;
  assign m_arvalid = s_arvalid & ~rd_full & run;
  assign s_arready = m_arready & ~rd_full & run;
  assign m_awvalid = s_awvalid & ~wr_full & run;
  assign s_awready = m_awready & ~wr_full & run;
  assign ar_hs     = s_arvalid & s_arready;
  assign aw_hs     = s_awvalid & s_awready;

  assign m_wvalid = s_wvalid & run;
  assign s_wready = m_wready & run;
  assign m_wdata  = s_wdata;
  assign m_wstrb  = s_wstrb;

  // Responses with no pending ID are held off the host side.
  assign s_rvalid = m_rvalid & ~rd_empty;
  assign m_rready = s_rready & ~rd_empty;
  assign s_rdata  = m_rdata;
  assign s_rresp  = m_rresp;
  assign r_hs     = s_rvalid & s_rready;
  assign s_bvalid = m_bvalid & ~wr_empty;
  assign m_bready = s_bready & ~wr_empty;
  assign s_bresp  = m_bresp;
  assign b_hs     = s_bvalid & s_bready;

  if (ADDR_OUT_WIDTH > ADDR_IN_WIDTH) begin : g_zext
    assign m_araddr = {{(ADDR_OUT_WIDTH - ADDR_IN_WIDTH){1'b0}}, s_araddr};
    assign m_awaddr = {{(ADDR_OUT_WIDTH - ADDR_IN_WIDTH){1'b0}}, s_awaddr};
  end else begin : g_trunc
    assign m_araddr = s_araddr[ADDR_OUT_WIDTH-1:0];
    assign m_awaddr = s_awaddr[ADDR_OUT_WIDTH-1:0];
  end

  mmio_id_fifo #(.WIDTH(ID_WIDTH), .DEPTH(DEPTH)) u_rd_fifo (
    .clk(clk), .reset(reset), .push(ar_hs), .push_data(s_arid), .pop(r_hs),
    .head(s_rid), .full(rd_full), .empty(rd_empty), .count(rd_outstanding)
  );

  mmio_id_fifo #(.WIDTH(ID_WIDTH), .DEPTH(DEPTH)) u_wr_fifo (
    .clk(clk), .reset(reset), .push(aw_hs), .push_data(s_awid), .pop(b_hs),
    .head(s_bid), .full(wr_full), .empty(wr_empty), .count(wr_outstanding)
  );

  assign err_orphan_d = err_orphan_q | (m_rvalid & rd_empty) | (m_bvalid & wr_empty);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_orphan_q <= 1'b0;
    else       err_orphan_q <= err_orphan_d;
  end

  assign err_orphan = err_orphan_q;
endmodule

// File: tb/tb_mmio_id_bridge.sv
// Directed bench for mmio_id_bridge: expected IDs are queued at request time
// and a negedge monitor matches them against host-side responses.
module tb_mmio_id_bridge;
  import mmio_id_pkg::*;

  localparam int IDW = 9;
  localparam int AIW = 18;
  localparam int AOW = 32;
  localparam int DW  = 64;
  localparam int CW  = 3;
  localparam int SW  = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic           s_arvalid, s_arready, s_rvalid, s_rready;
  logic [AIW-1:0] s_araddr, s_awaddr;
  logic [IDW-1:0] s_arid, s_rid, s_awid, s_bid;
  logic [DW-1:0]  s_rdata, s_wdata, m_rdata, m_wdata;
  logic [1:0]     s_rresp, s_bresp, m_rresp, m_bresp;
  logic           s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic [SW-1:0]  s_wstrb, m_wstrb;
  logic           m_arvalid, m_arready, m_rvalid, m_rready;
  logic [AOW-1:0] m_araddr, m_awaddr;
  logic           m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic [CW-1:0]  rd_outstanding, wr_outstanding;
  logic           err_orphan;

  int checks = 0;
  int errors = 0;
  int wr_peak = 0;
  logic [IDW-1:0] exp_rid_q[$];
  logic [IDW-1:0] exp_bid_q[$];

  mmio_id_bridge dut (
    .clk(clk), .reset(reset),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arid(s_arid),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rid(s_rid),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awid(s_awid),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp), .s_bid(s_bid),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
    .rd_outstanding(rd_outstanding), .wr_outstanding(wr_outstanding), .err_orphan(err_orphan)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog act=timeout exp=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (int'(wr_outstanding) > wr_peak) wr_peak = int'(wr_outstanding);
    if (s_rvalid && s_rready) begin
      if (exp_rid_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL r_unexpected act=%0h exp=none", s_rid);
      end else begin
        check("r_id", s_rid, exp_rid_q.pop_front());
        check("r_data", s_rdata, m_rdata);
        check("r_resp", s_rresp, m_rresp);
      end
    end
    if (s_bvalid && s_bready) begin
      if (exp_bid_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_unexpected act=%0h exp=none", s_bid);
      end else begin
        check("b_id", s_bid, exp_bid_q.pop_front());
        check("b_resp", s_bresp, m_bresp);
      end
    end
  end

  // Driver tasks: called and return just after a rising edge
  task automatic drive_idle();
    s_arvalid = 0; s_arid = '0; s_araddr = '0; m_arready = 0;
    m_rvalid = 0; m_rdata = '0; m_rresp = '0; s_rready = 0;
    s_awvalid = 0; s_awid = '0; s_awaddr = '0; m_awready = 0;
    s_wvalid = 0; s_wdata = '0; s_wstrb = '0; m_wready = 0;
    m_bvalid = 0; m_bresp = '0; s_bready = 0;
  endtask

  task automatic ar_issue(input logic [IDW-1:0] id, input logic [AIW-1:0] addr);
    int n = 0;
    s_arvalid = 1; s_arid = id; s_araddr = addr; m_arready = 1;
    @(negedge clk);
    while (!(s_arready && m_arvalid) && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n == 20) begin
      errors++;
      $display("FAIL ar_timeout act=no_handshake exp=handshake id=%0h", id);
    end else begin
      exp_rid_q.push_back(id);
    end
    @(posedge clk); #1;
    s_arvalid = 0; m_arready = 0;
  endtask

  task automatic r_issue(input logic [DW-1:0] data, input logic [1:0] resp);
    int n = 0;
    m_rvalid = 1; m_rdata = data; m_rresp = resp; s_rready = 1;
    @(negedge clk);
    while (!(s_rvalid && m_rready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n == 20) begin
      errors++;
      $display("FAIL r_timeout act=no_handshake exp=handshake");
    end
    @(posedge clk); #1;
    m_rvalid = 0; s_rready = 0;
  endtask

  task automatic check_all_idle(input string tag);
    check({tag, "_m_arvalid"}, m_arvalid, 0);
    check({tag, "_s_arready"}, s_arready, 0);
    check({tag, "_m_awvalid"}, m_awvalid, 0);
    check({tag, "_s_awready"}, s_awready, 0);
    check({tag, "_m_wvalid"}, m_wvalid, 0);
    check({tag, "_s_wready"}, s_wready, 0);
    check({tag, "_s_rvalid"}, s_rvalid, 0);
    check({tag, "_m_rready"}, m_rready, 0);
    check({tag, "_s_bvalid"}, s_bvalid, 0);
    check({tag, "_m_bready"}, m_bready, 0);
    check({tag, "_rd_out"}, rd_outstanding, 0);
    check({tag, "_wr_out"}, wr_outstanding, 0);
    check({tag, "_err_orphan"}, err_orphan, 0);
  endtask

  initial begin
    // Reset with all inputs active
    drive_idle();
    reset = 1;
    s_arvalid = 1; m_arready = 1; s_awvalid = 1; m_awready = 1;
    s_wvalid = 1; m_wready = 1; m_rvalid = 1; s_rready = 1; m_bvalid = 1; s_bready = 1;
    repeat (3) @(negedge clk);
    check_all_idle("reset");
    drive_idle();
    @(posedge clk); #1;
    reset = 0;

    // Address mapping and W pass-through
    s_araddr = 18'h3FFFF; s_awaddr = 18'h2A5A5;
    #1;
    check("ar_addr_map", m_araddr, 32'h0003FFFF);
    check("aw_addr_map", m_awaddr, 32'h0002A5A5);
    s_wvalid = 1; s_wdata = 64'hDEADBEEF01234567; s_wstrb = 8'hA5; m_wready = 0;
    #1;
    check("w_valid", m_wvalid, 1);
    check("w_data", m_wdata, 64'hDEADBEEF01234567);
    check("w_strb", m_wstrb, 8'hA5);
    check("w_ready_low", s_wready, 0);
    m_wready = 1;
    #1;
    check("w_ready_high", s_wready, 1);
    drive_idle();
    @(posedge clk); #1;

    // Read order
    ar_issue(9'h011, 18'h00100);
    ar_issue(9'h022, 18'h00200);
    ar_issue(9'h033, 18'h00300);
    check("order_rd_peak", rd_outstanding, 3);
    r_issue(64'h1111, RESP_OKAY);
    r_issue(64'h2222, RESP_SLVERR);
    r_issue(64'h3333, RESP_OKAY);
    check("order_rd_done", rd_outstanding, 0);

    // Full back-pressure
    for (int i = 0; i < 4; i++) ar_issue(IDW'(64 + i), AIW'(16 * i));
    check("full_count", rd_outstanding, 4);
    s_arvalid = 1; s_arid = 9'h044; m_arready = 1;
    @(negedge clk);
    check("full_s_arready", s_arready, 0);
    check("full_m_arvalid", m_arvalid, 0);
    @(posedge clk); #1;
    m_rvalid = 1; m_rdata = 64'h4040; m_rresp = RESP_OKAY; s_rready = 1;
    @(negedge clk);
    check("full_pop_cycle_arready", s_arready, 0);
    @(posedge clk); #1;
    m_rvalid = 0; s_rready = 0;
    @(negedge clk);
    check("full_after_pop_arready", s_arready, 1);
    check("full_after_pop_arvalid", m_arvalid, 1);
    exp_rid_q.push_back(9'h044);
    @(posedge clk); #1;
    s_arvalid = 0; m_arready = 0;
    check("full_refill", rd_outstanding, 4);
    for (int i = 0; i < 4; i++) r_issue(DW'(i + 100), RESP_OKAY);
    check("full_drained", rd_outstanding, 0);

    // Write wrap-around with 1-cycle B delay
    wr_peak = 0;
    for (int c = 0; c < 12; c++) begin
      if (c < 10) begin
        s_awvalid = 1; s_awid = IDW'(c); s_awaddr = AIW'(8 * c); m_awready = 1;
        s_wvalid = 1; s_wdata = DW'(c); s_wstrb = 8'hFF; m_wready = 1;
      end else begin
        s_awvalid = 0; m_awready = 0; s_wvalid = 0; m_wready = 0;
      end
      if (c >= 2) begin
        m_bvalid = 1; s_bready = 1;
        m_bresp = (c % 2 == 1) ? RESP_SLVERR : RESP_OKAY;
      end
      @(negedge clk);
      if (c < 10) begin
        check("wrap_awready", s_awready, 1);
        exp_bid_q.push_back(IDW'(c));
      end
      if (c >= 2) check("wrap_bvalid", s_bvalid, 1);
      @(posedge clk); #1;
    end
    drive_idle();
    check("wrap_peak", wr_peak, 2);
    check("wrap_wr_done", wr_outstanding, 0);
    check("wrap_queue_empty", exp_bid_q.size(), 0);

    // Simultaneous push and pop at count 2
    ar_issue(9'h051, 18'h00051);
    ar_issue(9'h052, 18'h00052);
    check("sim_count_before", rd_outstanding, 2);
    s_arvalid = 1; s_arid = 9'h053; m_arready = 1;
    m_rvalid = 1; m_rdata = 64'h5151; m_rresp = RESP_OKAY; s_rready = 1;
    @(negedge clk);
    check("sim_ar_hs", s_arready && m_arvalid, 1);
    check("sim_r_hs", s_rvalid && m_rready, 1);
    exp_rid_q.push_back(9'h053);
    @(posedge clk); #1;
    drive_idle();
    check("sim_count_after", rd_outstanding, 2);
    r_issue(64'h5252, RESP_OKAY);
    r_issue(64'h5353, RESP_SLVERR);
    check("sim_drained", rd_outstanding, 0);

    // Orphan response on empty read FIFO
    check("orphan_clear_before", err_orphan, 0);
    m_rvalid = 1; m_rdata = 64'hBAD; s_rready = 1;
    @(negedge clk);
    check("orphan_s_rvalid", s_rvalid, 0);
    check("orphan_m_rready", m_rready, 0);
    @(negedge clk);
    check("orphan_set", err_orphan, 1);
    check("orphan_held", s_rvalid, 0);
    @(posedge clk); #1;
    drive_idle();
    repeat (3) @(negedge clk);
    check("orphan_sticky", err_orphan, 1);
    @(posedge clk); #1;

    // Asynchronous reset mid-burst
    ar_issue(9'h061, 18'h00061);
    ar_issue(9'h062, 18'h00062);
    check("midrst_count", rd_outstanding, 2);
    s_arvalid = 1; s_arid = 9'h063; m_arready = 1; s_awvalid = 1; m_awready = 1;
    s_wvalid = 1; m_wready = 1; s_rready = 1; s_bready = 1;
    #2;
    reset = 1;
    #1;
    check_all_idle("midrst");
    exp_rid_q.delete();
    drive_idle();
    @(posedge clk); #1;
    reset = 0;
    m_rvalid = 1; m_rdata = 64'h7777; s_rready = 1;
    @(negedge clk);
    check("post_rst_s_rvalid", s_rvalid, 0);
    @(negedge clk);
    check("post_rst_orphan", err_orphan, 1);
    @(posedge clk); #1;
    drive_idle();

    // Final report
    repeat (2) @(posedge clk);
    check("end_rid_queue", exp_rid_q.size(), 0);
    check("end_bid_queue", exp_bid_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
